// File: rtl/zephyr_pkg.sv
// Shared types and defaults for the zephyr RAM arbiter.
package zephyr_pkg;

   typedef enum logic [1:0] {
      OWN_FREE = 2'd0,
      OWN_A    = 2'd1,
      OWN_B    = 2'd2
   } owner_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   localparam int DEF_ADDR_W   = 4;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_MAX_LOCK = 4;

endpackage

// File: rtl/zephyr_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module zephyr_rr_pick
   import zephyr_pkg::*;
(
   input  logic req_a,
   input  logic req_b,
   input  logic last,
   output logic pick_a,
   output logic pick_b
);

   // Tie resolves away from the most recently granted port.
   always_comb begin
      pick_a = req_a & (~req_b | (last == PORT_B));
      pick_b = req_b & ~pick_a;
   end

endmodule

// File: rtl/zephyr_mem_arbiter.sv
// Single-port RAM arbiter between the CPU path (A) and the loader/debug
// port (B), with bus lock and a bounded lock length.
// Build option ZEPHYR_ARB_CPU_PRIO_EN: port A wins every tie and its lock
// is unbounded; only port B's lock is limited to MAX_LOCK grants.
//
// state    | meaning
// OWN_FREE | no owner; grant by round-robin (or A priority)
// OWN_A    | A holds the lock; only A may be granted
// OWN_B    | B holds the lock; only B may be granted
module zephyr_mem_arbiter
   import zephyr_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_LOCK = DEF_MAX_LOCK
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              A_REQ,
   input  logic              A_WE,
   input  logic              A_LOCK,
   input  logic [ADDR_W-1:0] A_ADDR,
   input  logic [DATA_W-1:0] A_WDATA,
   output logic              A_GNT,
   output logic              A_RVALID,
   input  logic              B_REQ,
   input  logic              B_WE,
   input  logic              B_LOCK,
   input  logic [ADDR_W-1:0] B_ADDR,
   input  logic [DATA_W-1:0] B_WDATA,
   output logic              B_GNT,
   output logic              B_RVALID,
   output logic [DATA_W-1:0] RDATA,
   output logic              RAM_EN,
   output logic              RAM_WE,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic [DATA_W-1:0] RAM_WDATA,
   input  logic [DATA_W-1:0] RAM_RDATA
);

   localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   owner_t           owner_q, owner_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rv_a_q, rv_b_q;
   logic             gnt_a, gnt_b;
   logic             free_dec;
   logic             pick_a, pick_b;
   logic             tie_last;
   logic             limit_a;

`ifdef ZEPHYR_ARB_CPU_PRIO_EN
   // Pretending B was granted last makes every tie fall to A.
   assign tie_last = PORT_B;
   assign limit_a  = 1'b0;
`else
   assign tie_last = last_q;
   assign limit_a  = 1'b1;
`endif

   zephyr_rr_pick u_pick (
      .req_a  (A_REQ),
      .req_b  (B_REQ),
      .last   (tie_last),
      .pick_a (pick_a),
      .pick_b (pick_b)
   );

   // Grant decision and next owner/lock-count; a lapsed owner falls back to the free pick in the same cycle.
   always_comb begin
      gnt_a    = 1'b0;
      gnt_b    = 1'b0;
      free_dec = 1'b0;
      owner_d  = owner_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      case (owner_q)
         OWN_A: begin
            if (!A_REQ) begin
               free_dec = 1'b1;
            end else if (limit_a && (cnt_q == CNT_MAX) && B_REQ) begin
               gnt_b   = 1'b1;
               owner_d = OWN_FREE;
            end else begin
               gnt_a = 1'b1;
               if (A_LOCK) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
               else        owner_d = OWN_FREE;
            end
         end
         OWN_B: begin
            if (!B_REQ) begin
               free_dec = 1'b1;
            end else if ((cnt_q == CNT_MAX) && A_REQ) begin
               gnt_a   = 1'b1;
               owner_d = OWN_FREE;
            end else begin
               gnt_b = 1'b1;
               if (B_LOCK) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
               else        owner_d = OWN_FREE;
            end
         end
         default: free_dec = 1'b1;
      endcase
      if (free_dec) begin
         gnt_a   = pick_a;
         gnt_b   = pick_b;
         owner_d = OWN_FREE;
         if (pick_a && A_LOCK) begin
            owner_d = OWN_A;
            cnt_d   = CNT_ONE;
         end else if (pick_b && B_LOCK) begin
            owner_d = OWN_B;
            cnt_d   = CNT_ONE;
         end
      end
      if (RESET) begin
         gnt_a = 1'b0;
         gnt_b = 1'b0;
      end
      if (gnt_a)      last_d = PORT_A;
      else if (gnt_b) last_d = PORT_B;
   end

   // Owner, last-granted port, lock count and read-valid pipeline.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         owner_q <= OWN_FREE;
         last_q  <= PORT_B;
         cnt_q   <= '0;
         rv_a_q  <= 1'b0;
         rv_b_q  <= 1'b0;
      end else begin
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         rv_a_q  <= gnt_a & ~A_WE;
         rv_b_q  <= gnt_b & ~B_WE;
      end
   end

   assign A_GNT     = gnt_a;
   assign B_GNT     = gnt_b;
   assign RAM_EN    = gnt_a | gnt_b;
   assign RAM_WE    = (gnt_a & A_WE) | (gnt_b & B_WE);
   assign RAM_ADDR  = gnt_a ? A_ADDR  : (gnt_b ? B_ADDR  : '0);
   assign RAM_WDATA = gnt_a ? A_WDATA : (gnt_b ? B_WDATA : '0);
   assign A_RVALID  = rv_a_q & ~RESET;
   assign B_RVALID  = rv_b_q & ~RESET;
   assign RDATA     = (A_RVALID | B_RVALID) ? RAM_RDATA : '0;

endmodule

// File: tb/tb_zephyr_mem_arbiter.sv
// Bench for zephyr_mem_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level arbitration model.
module tb_zephyr_mem_arbiter;

   localparam int MAX_LOCK = 4;

   typedef struct packed {
      logic       we;
      logic       lock;
      logic [3:0] addr;
      logic [7:0] wdata;
   } txn_t;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       A_REQ = 1'b0, A_WE = 1'b0, A_LOCK = 1'b0;
   logic [3:0] A_ADDR = '0;
   logic [7:0] A_WDATA = '0;
   logic       B_REQ = 1'b0, B_WE = 1'b0, B_LOCK = 1'b0;
   logic [3:0] B_ADDR = '0;
   logic [7:0] B_WDATA = '0;
   logic       A_GNT, A_RVALID, B_GNT, B_RVALID;
   logic [7:0] RDATA;
   logic       RAM_EN, RAM_WE;
   logic [3:0] RAM_ADDR;
   logic [7:0] RAM_WDATA;
   logic [7:0] RAM_RDATA = '0;

   logic [7:0] mem [16];

   int   n_vec = 0;
   int   n_err = 0;

   txn_t qa[$];
   txn_t qb[$];

   // reference model state
   int         m_holder = -1;   // -1 nobody, 0 A, 1 B
   int         m_streak = 0;
   int         m_last   = 1;
   bit         exp_rv_a = 1'b0;
   bit         exp_rv_b = 1'b0;
   logic [7:0] exp_rd   = '0;
   logic [7:0] shadow [16];

   zephyr_mem_arbiter #(.ADDR_W(4), .DATA_W(8), .MAX_LOCK(MAX_LOCK)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .A_REQ     (A_REQ),
      .A_WE      (A_WE),
      .A_LOCK    (A_LOCK),
      .A_ADDR    (A_ADDR),
      .A_WDATA   (A_WDATA),
      .A_GNT     (A_GNT),
      .A_RVALID  (A_RVALID),
      .B_REQ     (B_REQ),
      .B_WE      (B_WE),
      .B_LOCK    (B_LOCK),
      .B_ADDR    (B_ADDR),
      .B_WDATA   (B_WDATA),
      .B_GNT     (B_GNT),
      .B_RVALID  (B_RVALID),
      .RDATA     (RDATA),
      .RAM_EN    (RAM_EN),
      .RAM_WE    (RAM_WE),
      .RAM_ADDR  (RAM_ADDR),
      .RAM_WDATA (RAM_WDATA),
      .RAM_RDATA (RAM_RDATA)
   );

   always #5 CLK = ~CLK;

   // single-port RAM with one cycle read latency
   always @(posedge CLK) begin
      if (RAM_EN) begin
         if (RAM_WE) mem[RAM_ADDR] <= RAM_WDATA;
         else        RAM_RDATA <= mem[RAM_ADDR];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic txn_t rand_txn();
      txn_t t;
      t.we    = 1'($urandom_range(0, 1));
      t.lock  = 1'($urandom_range(0, 1));
      t.addr  = 4'($urandom_range(0, 15));
      t.wdata = 8'($urandom_range(0, 255));
      return t;
   endfunction

   function automatic bit lock_limited(input int p);
`ifdef ZEPHYR_ARB_CPU_PRIO_EN
      return p == 1;
`else
      return p >= 0;
`endif
   endfunction

   function automatic bit a_prio();
`ifdef ZEPHYR_ARB_CPU_PRIO_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // One clock: present queue heads, check DUT against model, advance model.
   task automatic step(input bit rst);
      txn_t ta, tb;
      bit   req [2];
      bit   lk  [2];
      int   win, h, s, o;
      @(negedge CLK);
      req[0] = qa.size() != 0;
      req[1] = qb.size() != 0;
      ta = req[0] ? qa[0] : rand_txn();
      tb = req[1] ? qb[0] : rand_txn();
      lk[0] = ta.lock;
      lk[1] = tb.lock;
      RESET = rst;
      A_REQ = req[0]; A_WE = ta.we; A_LOCK = ta.lock; A_ADDR = ta.addr; A_WDATA = ta.wdata;
      B_REQ = req[1]; B_WE = tb.we; B_LOCK = tb.lock; B_ADDR = tb.addr; B_WDATA = tb.wdata;
      #1;
      win = -1;
      h   = m_holder;
      s   = m_streak;
      if (!rst) begin
         if (m_holder >= 0 && req[m_holder]) begin
            o = 1 - m_holder;
            if (m_streak >= MAX_LOCK && req[o] && lock_limited(m_holder)) begin
               win = o;
               h   = -1;
            end else begin
               win = m_holder;
               if (lk[m_holder]) s = (s + 1 > MAX_LOCK) ? MAX_LOCK : s + 1;
               else              h = -1;
            end
         end else begin
            h = -1;
            if (req[0] && req[1]) win = a_prio() ? 0 : 1 - m_last;
            else if (req[0])      win = 0;
            else if (req[1])      win = 1;
            if (win >= 0 && lk[win]) begin
               h = win;
               s = 1;
            end
         end
      end
      chk("a_gnt",     32'(A_GNT),     32'(win == 0));
      chk("b_gnt",     32'(B_GNT),     32'(win == 1));
      chk("ram_en",    32'(RAM_EN),    32'(win >= 0));
      chk("ram_we",    32'(RAM_WE),    32'(win == 0 ? ta.we : (win == 1 ? tb.we : 1'b0)));
      chk("ram_addr",  32'(RAM_ADDR),  32'(win == 0 ? ta.addr : (win == 1 ? tb.addr : 4'h0)));
      chk("ram_wdata", 32'(RAM_WDATA), 32'(win == 0 ? ta.wdata : (win == 1 ? tb.wdata : 8'h00)));
      chk("a_rvalid",  32'(A_RVALID),  32'(exp_rv_a && !rst));
      chk("b_rvalid",  32'(B_RVALID),  32'(exp_rv_b && !rst));
      if (rst)                       chk("rdata_rst", 32'(RDATA), 32'h0);
      else if (exp_rv_a || exp_rv_b) chk("rdata",     32'(RDATA), 32'(exp_rd));
      @(posedge CLK);
      if (rst) begin
         m_holder = -1;
         m_streak = 0;
         m_last   = 1;
         exp_rv_a = 1'b0;
         exp_rv_b = 1'b0;
      end else begin
         m_holder = h;
         m_streak = s;
         if (win >= 0) m_last = win;
         exp_rv_a = (win == 0) && !ta.we;
         exp_rv_b = (win == 1) && !tb.we;
         if (win == 0) begin
            if (ta.we) shadow[ta.addr] = ta.wdata;
            else       exp_rd = shadow[ta.addr];
            void'(qa.pop_front());
         end else if (win == 1) begin
            if (tb.we) shadow[tb.addr] = tb.wdata;
            else       exp_rd = shadow[tb.addr];
            void'(qb.pop_front());
         end
      end
   endtask

   task automatic drain();
      int budget = 200;
      while ((qa.size() != 0 || qb.size() != 0) && budget > 0) begin
         step(1'b0);
         budget--;
      end
      chk("drain_timeout", 32'(budget > 0), 32'h1);
      qa.delete();
      qb.delete();
      step(1'b0);
      step(1'b0);
   endtask

   function automatic txn_t mk(input bit we, input bit lock, input logic [3:0] addr, input logic [7:0] wdata);
      txn_t t;
      t.we = we; t.lock = lock; t.addr = addr; t.wdata = wdata;
      return t;
   endfunction

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem[i]    = 8'h00;
         shadow[i] = 8'h00;
      end

      // reset with both ports requesting, then A wins the first tie
      qa.push_back(mk(1'b0, 1'b0, 4'h3, 8'h00));
      qb.push_back(mk(1'b0, 1'b0, 4'h5, 8'h00));
      step(1'b1);
      step(1'b1);
      drain();

      // read latency at the top address
      qb.push_back(mk(1'b1, 1'b0, 4'hF, 8'hFF));
      drain();
      qa.push_back(mk(1'b0, 1'b0, 4'hF, 8'h00));
      drain();

      // round-robin reads on both ports
      for (int i = 0; i < 3; i++) begin
         qa.push_back(mk(1'b0, 1'b0, 4'(i), 8'h00));
         qb.push_back(mk(1'b0, 1'b0, 4'(i + 8), 8'h00));
      end
      drain();

      // same-cycle A write and B read of one address, LAST = B
      qb.push_back(mk(1'b0, 1'b0, 4'h2, 8'h00));
      drain();
      qa.push_back(mk(1'b1, 1'b0, 4'h1, 8'h4F));
      qb.push_back(mk(1'b0, 1'b0, 4'h1, 8'h00));
      drain();

      // loader burst under lock with the CPU waiting
      for (int i = 0; i < 8; i++) qb.push_back(mk(1'b1, 1'b1, 4'(i), 8'(8'h10 + i)));
      step(1'b0);
      qa.push_back(mk(1'b0, 1'b1, 4'hF, 8'h00));
      qa.push_back(mk(1'b0, 1'b0, 4'h1, 8'h00));
      drain();
      for (int i = 0; i < 8; i++) chk("burst_mem", 32'(mem[i]), 32'(8'h10 + i));

      // continuous contention, both ports locked
      for (int i = 0; i < 10; i++) begin
         qa.push_back(mk(1'b0, 1'b1, 4'(i), 8'h00));
         qb.push_back(mk(1'b1, 1'b1, 4'(i), 8'(i)));
      end
      drain();

      // random traffic with occasional mid-operation resets
      for (int c = 0; c < 600; c++) begin
         if (qa.size() == 0 && $urandom_range(0, 9) < 7) qa.push_back(rand_txn());
         if (qb.size() == 0 && $urandom_range(0, 9) < 7) qb.push_back(rand_txn());
         step($urandom_range(0, 63) == 0);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
